// File: rtl/id_ex_operand_stage_pkg.sv
// id_ex_operand_stage_pkg: shared widths, ALU codes, bypass selects and the ID/EX record
package pipe_pkg;
    localparam int DATA_WIDTH    = 32;
    localparam int OPCODE_LENGTH = 4;
    localparam int REG_ADDR_W    = 5;
    typedef enum logic [OPCODE_LENGTH-1:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_XOR = 4'b0011,
        ALU_SLL = 4'b0100,
        ALU_SRL = 4'b0101,
        ALU_SUB = 4'b0110,
        ALU_SRA = 4'b0111,
        ALU_EQ  = 4'b1000
    } alu_op_t;
    typedef enum logic [1:0] {FWD_REG, FWD_EXMEM, FWD_MEMWB} fwd_sel_t;
    typedef struct packed {
        logic                  valid;
        logic                  regwrite;
        logic                  memread;
        logic                  memwrite;
        logic                  alusrc;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_WIDTH-1:0] rs1_data;
        logic [DATA_WIDTH-1:0] rs2_data;
        logic [DATA_WIDTH-1:0] imm;
        alu_op_t               alu_op;
    } id_ex_t;
    localparam id_ex_t ID_EX_BUBBLE = '0;
endpackage

// File: rtl/id_ex_operand_stage_if.sv
// id_ex_operand_stage_if: ID-side, bypass and ALU-side signals of the ID/EX operand stage
interface id_ex_operand_stage_if;
    import pipe_pkg::*;
    logic                     id_valid;
    logic [REG_ADDR_W-1:0]    id_rs1_addr;
    logic [REG_ADDR_W-1:0]    id_rs2_addr;
    logic [REG_ADDR_W-1:0]    id_rd_addr;
    logic [DATA_WIDTH-1:0]    id_rs1_data;
    logic [DATA_WIDTH-1:0]    id_rs2_data;
    logic [DATA_WIDTH-1:0]    id_imm;
    logic [OPCODE_LENGTH-1:0] id_alu_op;
    logic                     id_alusrc;
    logic                     id_regwrite;
    logic                     id_memread;
    logic                     id_memwrite;
    logic                     stall;
    logic                     flush;
    logic [REG_ADDR_W-1:0]    exmem_rd;
    logic                     exmem_regwrite;
    logic [DATA_WIDTH-1:0]    exmem_result;
    logic [REG_ADDR_W-1:0]    memwb_rd;
    logic                     memwb_regwrite;
    logic [DATA_WIDTH-1:0]    memwb_result;
    logic [DATA_WIDTH-1:0]    SrcA;
    logic [DATA_WIDTH-1:0]    SrcB;
    logic [OPCODE_LENGTH-1:0] Operation;
    logic [DATA_WIDTH-1:0]    ex_store_data;
    logic [REG_ADDR_W-1:0]    ex_rd;
    logic                     ex_regwrite;
    logic                     ex_memread;
    logic                     ex_memwrite;
    logic                     ex_valid;
    logic                     load_use_hazard;
    modport master (
        output id_valid, id_rs1_addr, id_rs2_addr, id_rd_addr, id_rs1_data, id_rs2_data, id_imm,
               id_alu_op, id_alusrc, id_regwrite, id_memread, id_memwrite, stall, flush,
               exmem_rd, exmem_regwrite, exmem_result, memwb_rd, memwb_regwrite, memwb_result,
        input  SrcA, SrcB, Operation, ex_store_data, ex_rd, ex_regwrite, ex_memread, ex_memwrite,
               ex_valid, load_use_hazard
    );
    modport slave (
        input  id_valid, id_rs1_addr, id_rs2_addr, id_rd_addr, id_rs1_data, id_rs2_data, id_imm,
               id_alu_op, id_alusrc, id_regwrite, id_memread, id_memwrite, stall, flush,
               exmem_rd, exmem_regwrite, exmem_result, memwb_rd, memwb_regwrite, memwb_result,
        output SrcA, SrcB, Operation, ex_store_data, ex_rd, ex_regwrite, ex_memread, ex_memwrite,
               ex_valid, load_use_hazard
    );
endinterface

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// fwd_mux: picks the newest value of one source register from EX/MEM, MEM/WB or the register file
module fwd_mux
    import pipe_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs_i,
    input  logic [DATA_WIDTH-1:0] reg_data_i,
    input  logic                  exmem_regwrite_i,
    input  logic [REG_ADDR_W-1:0] exmem_rd_i,
    input  logic [DATA_WIDTH-1:0] exmem_result_i,
    input  logic                  memwb_regwrite_i,
    input  logic [REG_ADDR_W-1:0] memwb_rd_i,
    input  logic [DATA_WIDTH-1:0] memwb_result_i,
    output fwd_sel_t              sel_o,
    output logic [DATA_WIDTH-1:0] data_o
);
    // x0 is never bypassed; the younger EX/MEM producer wins over MEM/WB
    always_comb sel_o = (rs_i == '0) ? FWD_REG :
                        (exmem_regwrite_i && exmem_rd_i == rs_i) ? FWD_EXMEM :
                        (memwb_regwrite_i && memwb_rd_i == rs_i) ? FWD_MEMWB : FWD_REG;
    // route the selected source onto the operand
    always_comb data_o = (sel_o == FWD_EXMEM) ? exmem_result_i :
                         (sel_o == FWD_MEMWB) ? memwb_result_i : reg_data_i;
endmodule

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX register with RAW bypass into the ALU and load-use bubble insertion
module id_ex_operand_stage
    import pipe_pkg::*;
(
    input  logic clk,
    input  logic reset,
    id_ex_operand_stage_if.slave bus
);
    id_ex_t                ex_q, ex_d, id_cap;
    logic                  load_use;
    fwd_sel_t              sel_a, sel_b;
    logic [DATA_WIDTH-1:0] fwd_a, fwd_b;
    // a load in EX whose rd feeds the instruction in ID cannot be bypassed in time
    always_comb load_use = ex_q.valid && ex_q.memread && ex_q.rd != '0 && bus.id_valid &&
                           (ex_q.rd == bus.id_rs1_addr || ex_q.rd == bus.id_rs2_addr);
    // ID fields as captured; side-effect controls are gated so an empty slot never acts
    always_comb begin
        id_cap.valid    = bus.id_valid;
        id_cap.regwrite = bus.id_regwrite && bus.id_valid;
        id_cap.memread  = bus.id_memread && bus.id_valid;
        id_cap.memwrite = bus.id_memwrite && bus.id_valid;
        id_cap.alusrc   = bus.id_alusrc;
        id_cap.rs1      = bus.id_rs1_addr;
        id_cap.rs2      = bus.id_rs2_addr;
        id_cap.rd       = bus.id_rd_addr;
        id_cap.rs1_data = bus.id_rs1_data;
        id_cap.rs2_data = bus.id_rs2_data;
        id_cap.imm      = bus.id_imm;
        id_cap.alu_op   = alu_op_t'(bus.id_alu_op);
    end
    // bubble beats hold beats load; a load-use bubble lets the hazard resolve while ID stalls
    always_comb ex_d = (bus.flush || load_use) ? ID_EX_BUBBLE : bus.stall ? ex_q : id_cap;
    // pipeline register, cleared to a bubble whenever reset is seen
    always_ff @(posedge clk or posedge reset) begin
        if (reset) ex_q <= ID_EX_BUBBLE;
        else       ex_q <= ex_d;
    end
    fwd_mux u_fwd_a (
        .rs_i(ex_q.rs1), .reg_data_i(ex_q.rs1_data),
        .exmem_regwrite_i(bus.exmem_regwrite), .exmem_rd_i(bus.exmem_rd), .exmem_result_i(bus.exmem_result),
        .memwb_regwrite_i(bus.memwb_regwrite), .memwb_rd_i(bus.memwb_rd), .memwb_result_i(bus.memwb_result),
        .sel_o(sel_a), .data_o(fwd_a)
    );
    fwd_mux u_fwd_b (
        .rs_i(ex_q.rs2), .reg_data_i(ex_q.rs2_data),
        .exmem_regwrite_i(bus.exmem_regwrite), .exmem_rd_i(bus.exmem_rd), .exmem_result_i(bus.exmem_result),
        .memwb_regwrite_i(bus.memwb_regwrite), .memwb_rd_i(bus.memwb_rd), .memwb_result_i(bus.memwb_result),
        .sel_o(sel_b), .data_o(fwd_b)
    );
    // x0 operands must always come straight from the registered value
    always_comb assert ((ex_q.rs1 != '0 || sel_a == FWD_REG) && (ex_q.rs2 != '0 || sel_b == FWD_REG));
    // ALU-facing outputs straight from the register and the bypass muxes
    always_comb begin
        bus.SrcA            = fwd_a;
        bus.SrcB            = ex_q.alusrc ? ex_q.imm : fwd_b;
        bus.ex_store_data   = fwd_b;
        bus.Operation       = ex_q.alu_op;
        bus.ex_rd           = ex_q.rd;
        bus.ex_regwrite     = ex_q.regwrite;
        bus.ex_memread      = ex_q.memread;
        bus.ex_memwrite     = ex_q.memwrite;
        bus.ex_valid        = ex_q.valid;
        bus.load_use_hazard = load_use;
    end
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage: directed and random checks of the ID/EX operand stage against an instruction-level model
module tb_id_ex_operand_stage;
    import pipe_pkg::*;
    typedef struct {
        bit        valid, rw, mr, mw, alusrc;
        bit [4:0]  rs1, rs2, rd;
        bit [31:0] d1, d2, imm;
        bit [3:0]  op;
    } instr_t;
    logic   clk = 1'b0;
    logic   reset = 1'b1;
    int     total = 0;
    int     bad = 0;
    instr_t ex_m, id, nop;
    id_ex_operand_stage_if bus();
    id_ex_operand_stage dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic instr_t mk(bit v, bit [4:0] a, bit [4:0] b, bit [4:0] d, bit [31:0] x,
                                  bit [31:0] y, bit [31:0] im, bit [3:0] op, bit src,
                                  bit rw, bit mr, bit mw);
        instr_t i;
        i.valid = v; i.rs1 = a; i.rs2 = b; i.rd = d; i.d1 = x; i.d2 = y; i.imm = im;
        i.op = op; i.alusrc = src; i.rw = rw; i.mr = mr; i.mw = mw;
        return i;
    endfunction

    task automatic drive_id();
        bus.id_valid = id.valid;      bus.id_rs1_addr = id.rs1;  bus.id_rs2_addr = id.rs2;
        bus.id_rd_addr = id.rd;       bus.id_rs1_data = id.d1;   bus.id_rs2_data = id.d2;
        bus.id_imm = id.imm;          bus.id_alu_op = id.op;     bus.id_alusrc = id.alusrc;
        bus.id_regwrite = id.rw;      bus.id_memread = id.mr;    bus.id_memwrite = id.mw;
    endtask

    // newest architectural value of a source register as seen by the instruction in EX
    function automatic bit [31:0] fwd(bit [4:0] rs, bit [31:0] rv);
        if (rs == 0) return rv;
        if (bus.exmem_regwrite && bus.exmem_rd == rs) return bus.exmem_result;
        if (bus.memwb_regwrite && bus.memwb_rd == rs) return bus.memwb_result;
        return rv;
    endfunction

    function automatic bit hz();
        return ex_m.valid && ex_m.mr && ex_m.rd != 0 && id.valid && (ex_m.rd == id.rs1 || ex_m.rd == id.rs2);
    endfunction

    task automatic check_outputs();
        bit [31:0] fa, fb;
        fa = fwd(ex_m.rs1, ex_m.d1);
        fb = fwd(ex_m.rs2, ex_m.d2);
        chk("SrcA", bus.SrcA, fa);
        chk("SrcB", bus.SrcB, ex_m.alusrc ? ex_m.imm : fb);
        chk("ex_store_data", bus.ex_store_data, fb);
        chk("Operation", 32'(bus.Operation), 32'(ex_m.op));
        chk("ex_rd", 32'(bus.ex_rd), 32'(ex_m.rd));
        chk("ex_regwrite", 32'(bus.ex_regwrite), 32'(ex_m.rw));
        chk("ex_memread", 32'(bus.ex_memread), 32'(ex_m.mr));
        chk("ex_memwrite", 32'(bus.ex_memwrite), 32'(ex_m.mw));
        chk("ex_valid", 32'(bus.ex_valid), 32'(ex_m.valid));
        chk("load_use_hazard", 32'(bus.load_use_hazard), 32'(hz()));
    endtask

    // one clock edge: bubble, hold or capture the instruction in ID
    task automatic tick();
        if (bus.flush || hz()) ex_m = nop;
        else if (!bus.stall) begin
            ex_m = id;
            if (!id.valid) begin
                ex_m.rw = 0; ex_m.mr = 0; ex_m.mw = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load(input instr_t i);
        id = i;
        drive_id();
        tick();
    endtask

    initial begin
        nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        ex_m = nop;
        id = nop;
        drive_id();
        bus.stall = 0; bus.flush = 0;
        bus.exmem_rd = 0; bus.exmem_regwrite = 0; bus.exmem_result = 0;
        bus.memwb_rd = 0; bus.memwb_regwrite = 0; bus.memwb_result = 0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        chk("reset_valid", 32'(bus.ex_valid), 32'd0);
        reset = 0;
        // reset asserted between edges clears the stage immediately
        load(mk(1, 1, 2, 3, 32'h11, 32'h22, 0, 4'b0010, 0, 1, 0, 0));
        chk("t1_op", 32'(bus.Operation), 32'd2);
        chk("t1_srca", bus.SrcA, 32'h11);
        #2 reset = 1;
        #1;
        ex_m = nop;
        check_outputs();
        chk("t1_rst_srca", bus.SrcA, 32'd0);
        chk("t1_rst_op", 32'(bus.Operation), 32'd0);
        #1 reset = 0;
        tick();
        check_outputs();
        // bypass priority
        load(mk(1, 5, 6, 8, 32'h1111, 32'h2222, 0, 4'b0010, 0, 1, 0, 0));
        bus.exmem_rd = 5; bus.exmem_regwrite = 1; bus.exmem_result = 32'hAAAA;
        bus.memwb_rd = 5; bus.memwb_regwrite = 1; bus.memwb_result = 32'hBBBB;
        #1;
        chk("t2_exmem", bus.SrcA, 32'hAAAA);
        check_outputs();
        bus.exmem_regwrite = 0;
        #1;
        chk("t2_memwb", bus.SrcA, 32'hBBBB);
        load(mk(1, 0, 6, 8, 32'h1234, 32'h2222, 0, 4'b0010, 0, 1, 0, 0));
        bus.exmem_rd = 0; bus.exmem_regwrite = 1; bus.memwb_rd = 0;
        #1;
        chk("t2_x0", bus.SrcA, 32'h1234);
        check_outputs();
        // immediate operand while rs2 is still bypassed to the store path
        bus.exmem_regwrite = 0; bus.memwb_regwrite = 0;
        load(mk(1, 1, 9, 4, 32'h5, 32'h99, 32'hFFFFFFFC, 4'b0010, 1, 0, 0, 1));
        bus.exmem_rd = 9; bus.exmem_regwrite = 1; bus.exmem_result = 32'h10;
        #1;
        chk("t3_srcb", bus.SrcB, 32'hFFFFFFFC);
        chk("t3_store", bus.ex_store_data, 32'h10);
        check_outputs();
        bus.exmem_regwrite = 0;
        // load-use
        load(mk(1, 1, 2, 7, 32'h1, 32'h2, 32'h4, 4'b0010, 1, 1, 1, 0));
        id = mk(1, 3, 7, 9, 32'h3, 32'h7, 0, 4'b0001, 0, 1, 0, 0);
        drive_id();
        #1;
        chk("t4_hazard", 32'(bus.load_use_hazard), 32'd1);
        check_outputs();
        tick();
        chk("t4_valid", 32'(bus.ex_valid), 32'd0);
        chk("t4_regwrite", 32'(bus.ex_regwrite), 32'd0);
        check_outputs();
        // stall holds, stall with flush bubbles
        load(mk(1, 1, 2, 3, 32'h30, 32'h10, 0, 4'b0110, 0, 1, 0, 0));
        id = mk(1, 4, 5, 6, 32'h1, 32'h2, 0, 4'b0010, 0, 1, 0, 0);
        drive_id();
        bus.stall = 1;
        repeat (3) begin
            tick();
            chk("t5_hold", 32'(bus.Operation), 32'b0110);
            check_outputs();
        end
        bus.flush = 1;
        tick();
        chk("t5_flush_valid", 32'(bus.ex_valid), 32'd0);
        chk("t5_flush_op", 32'(bus.Operation), 32'd0);
        check_outputs();
        bus.stall = 0; bus.flush = 0;
        // invalid capture
        load(mk(0, 1, 2, 3, 32'h1, 32'h2, 0, 4'b0010, 0, 1, 1, 1));
        chk("t6_regwrite", 32'(bus.ex_regwrite), 32'd0);
        chk("t6_valid", 32'(bus.ex_valid), 32'd0);
        check_outputs();
        // random traffic with small register indices so bypasses and hazards are frequent
        for (int i = 0; i < 400; i++) begin
            id = mk(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), $urandom, $urandom, $urandom, 4'($urandom_range(0, 8)),
                    1'($urandom), 1'($urandom), 1'($urandom_range(0, 2) == 0), 1'($urandom));
            drive_id();
            bus.stall = ($urandom_range(0, 3) == 0);
            bus.flush = ($urandom_range(0, 7) == 0);
            bus.exmem_rd = 5'($urandom_range(0, 7)); bus.exmem_regwrite = 1'($urandom); bus.exmem_result = $urandom;
            bus.memwb_rd = 5'($urandom_range(0, 7)); bus.memwb_regwrite = 1'($urandom); bus.memwb_result = $urandom;
            #1;
            check_outputs();
            if (i == 200) begin
                reset = 1;
                #1;
                ex_m = nop;
                check_outputs();
                reset = 0;
            end
            tick();
            check_outputs();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
